sl3_tx_packet_arbiter: RTL and testbench
========================================

Name: sl3_tx_packet_arbiter

Overview:
N-channel successor to the SL3 TX mux.
- Frames each input stream into fixed-size packets; packet size is SW-programmable per channel.
- Buffers each channel in its own FIFO.
- Arbitrates whole packets round-robin onto one SL3 user-network TX port through a registered valid/ready output stage.
- Sits between the PCIe/distributor/result-combiner streams and the SL3 shell; NUM_CH replaces the fixed 3-way selection.

Parameters:
- NUM_CH, 3: number of input channels (2..8).
- DATA_W, 128: line width in bits.
- FIFO_DEPTH_BITS, 9: per-channel FIFO depth is 2^FIFO_DEPTH_BITS lines.
- PKT_SIZE_BITS, 8: width of the packet-length fields.
- DEV_ID_W, 4: destination device-id width.
- META_W, 16: stream metadata width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start_core  in  1  single-cycle soft clear
- ch_data  in  NUM_CH*DATA_W  per-channel line data; channel i occupies slice i
- ch_valid  in  NUM_CH  per-channel line valid
- ch_ready  out  NUM_CH  per-channel ready; equals ~fifo_full
- ch_dest  in  NUM_CH*DEV_ID_W  per-channel destination device id
- ch_metadata  in  NUM_CH*META_W  per-channel stream tag (DATA/TREE_WEIGHT/TREE_FINDEX/RESULTS)
- ch_pkt_numcls_minus_one  in  NUM_CH*PKT_SIZE_BITS  packet length minus one, per channel
- ch_weight  in  NUM_CH*4  consecutive-packet quota; used only with the optional feature
- tx_data  out  DATA_W  output line
- tx_address  out  DEV_ID_W+6  {2'b0, dest, 4'b0000}
- tx_metadata  out  META_W  stream tag
- tx_last  out  1  last line of packet
- tx_valid  out  1  output valid
- tx_ready  in  1  shell ready
- num_sent_lines  out  32  total lines accepted on all channels
- num_sent_packets  out  32  total packets emitted on tx
- grant_ch  out  $clog2(NUM_CH)  currently locked channel (debug)

Behaviour:
- Reset (rst_n=0, or start_core=1):
  - Clears framer counters, FIFOs, lock, RR pointer (to 0), output register, and both 32-bit counters.
  - Outputs: tx_valid=0, tx_last=0, grant_ch=0, counters=0; ch_ready=all 1 from the next cycle.
- Channel accept: a line on channel i is accepted when ch_valid[i] & ch_ready[i]. Nothing is written when the FIFO is full; the source must hold its data.
- Framer (per channel):
  - cnt_i increments on each accept.
  - Line is marked last when cnt_i == len_i; cnt_i then wraps to 0.
  - len_i latches ch_pkt_numcls_minus_one at the first line of a packet (cnt_i==0), so mid-packet config changes take effect on the next packet.
  - Stored word = {data, dest, metadata, last}; dest/metadata are sampled per line.
  - Length 0 gives 1-line packets (last on every line).
- Arbiter FSM:
  - IDLE:
    - Grant the first channel with a non-empty FIFO, scanning from rr_ptr upward with wrap-around.
    - Go to LOCKED the same cycle the grant is made.
    - With no requests, stay in IDLE.
  - LOCKED:
    - Pops the granted FIFO whenever the output register is empty or is being drained (tx_ready).
    - When the popped word has last=1: rr_ptr <= grant+1 mod NUM_CH, return to IDLE.
    - Other channels never interleave inside a packet.
    - A FIFO that is empty mid-packet stalls the output (tx_valid=0) while the lock is held.
- Output stage:
  - Single register; full throughput (1 line/cycle) while tx_ready=1.
  - tx_* hold stable while tx_valid & ~tx_ready.
  - Latency: line accepted at cycle t on an idle arbiter reaches tx_valid at t+2.
- Counters:
  - num_sent_lines += popcount of accepts per cycle.
  - num_sent_packets += 1 on tx_valid & tx_ready & tx_last.
  - Both wrap at 2^32.
- Simultaneous events:
  - Accepts on all channels in the same cycle are all taken.
  - A grant and a last-pop in the same cycle: the new grant starts next cycle, giving one idle bubble per packet boundary.
- start_core mid-packet: the partial packet is discarded and no tx_last is emitted for it.

Optional Feature:
- SL3_TX_WEIGHTED_ARB_EN defined:
  - Granted channel i keeps the lock for up to ch_weight[i] consecutive packets, with a weight of 0 treated as 1.
  - After each packet it stays in LOCKED only while its FIFO is non-empty and the quota is not exhausted.
  - The quota counter reloads on each new grant.
- Undefined: strict one-packet round-robin; ch_weight is ignored.

Decomposition:
- Shared package (DTEngine_Types):
  - TxChWord struct {data, dest, metadata, last}.
  - Stream tag constants (DATA_STREAM, TREE_WEIGHT_STREAM, TREE_FINDEX_STREAM, RESULTS_STREAM).
  - Default packet lengths.
- Sub-module sl3_ch_framer: per-channel counter, length latch and last marking, wrapping quick_fifo. Instantiated NUM_CH times via generate.

Test Plan:
- NUM_CH=3; lengths 15/0/3; one packet per channel, all valid at cycle 0 -> tx order ch0 (16 lines), ch1 (1), ch2 (4); tx_last on lines 16/17/21; num_sent_packets=3.
- ch0 and ch2 stream continuously with length 3 -> alternating 4-line packets 0,2,0,2, no interleaving; grant_ch toggles only after tx_last.
- tx_ready held low 20 cycles mid-packet -> tx_data stable throughout; ch_ready drops once the FIFO holds 512 lines; no lines lost; num_sent_lines=ch_accepts.
- ch1 length changed from 7 to 1 after its 3rd line -> current packet still 8 lines, next packet 2 lines.
- start_core asserted after 5 of 16 lines -> tx_valid=0 next cycle, counters=0; a subsequent packet emits a full 16 lines with correct tx_last.
- SL3_TX_WEIGHTED_ARB_EN, weights 3/1, both backlogged, length 0 -> tx channel sequence 0,0,0,1,0,0,0,1.

Source files
------------

// File: rtl/sl3_tx_packet_arbiter_pkg.sv
// Shared types and constants for the SL3 TX packet arbiter and its per-channel framers.
package sl3_tx_packet_arbiter_pkg;

   localparam int DEF_DATA_W   = 128;
   localparam int DEF_DEV_ID_W = 4;
   localparam int DEF_META_W   = 16;

   localparam logic [DEF_META_W-1:0] DATA_STREAM        = 16'h0001;
   localparam logic [DEF_META_W-1:0] TREE_WEIGHT_STREAM = 16'h0002;
   localparam logic [DEF_META_W-1:0] TREE_FINDEX_STREAM = 16'h0003;
   localparam logic [DEF_META_W-1:0] RESULTS_STREAM     = 16'h0004;

   localparam logic [7:0] DEF_DATA_PKT_NUMCLS_MINUS_ONE   = 8'd15;
   localparam logic [7:0] DEF_TREE_PKT_NUMCLS_MINUS_ONE   = 8'd3;
   localparam logic [7:0] DEF_RESULT_PKT_NUMCLS_MINUS_ONE = 8'd0;

   // Default-width view of a stored FIFO word; the RTL packs the same order generically.
   typedef struct packed {
      logic [DEF_DATA_W-1:0]   data;
      logic [DEF_DEV_ID_W-1:0] dest;
      logic [DEF_META_W-1:0]   metadata;
      logic                    last;
   } tx_ch_word_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   function automatic int rr_next(input int cur, input int n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/sl3_tx_packet_arbiter_ch_framer.sv
// Per-channel framer: counts lines into fixed-size packets, marks the last line
// and buffers {data, dest, metadata, last} words in a first-word-fall-through FIFO.
module sl3_tx_packet_arbiter_ch_framer
   import sl3_tx_packet_arbiter_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int DEV_ID_W      = DEF_DEV_ID_W,
   parameter int META_W        = DEF_META_W,
   parameter int PKT_SIZE_BITS = 8,
   parameter int DEPTH_BITS    = 9
) (
   input  logic                                 clk,
   input  logic                                 clr_i,
   input  logic [DATA_W-1:0]                    data_i,
   input  logic [DEV_ID_W-1:0]                  dest_i,
   input  logic [META_W-1:0]                    meta_i,
   input  logic                                 valid_i,
   input  logic [PKT_SIZE_BITS-1:0]             len_i,
   input  logic                                 pop_i,
   output logic                                 ready_o,
   output logic [DATA_W+DEV_ID_W+META_W:0]      word_o,
   output logic                                 empty_o,
   output logic                                 multi_o
);

   localparam int WORD_W = DATA_W + DEV_ID_W + META_W + 1;
   localparam int DEPTH  = 1 << DEPTH_BITS;

   logic [WORD_W-1:0]        mem_q [DEPTH];
   logic [DEPTH_BITS-1:0]    wr_ptr_q, rd_ptr_q;
   logic [DEPTH_BITS:0]      count_q;
   logic [PKT_SIZE_BITS-1:0] cnt_q, len_q, len_cur;
   logic                     full, push, pop_ok, line_last;

   assign full      = count_q[DEPTH_BITS];
   assign ready_o   = ~full;
   assign empty_o   = (count_q == '0);
   assign multi_o   = (count_q > (DEPTH_BITS+1)'(1));
   assign push      = valid_i & ~full;
   assign pop_ok    = pop_i & ~empty_o;
   // The first line of a packet uses the live length; later lines use the latched one.
   assign len_cur   = (cnt_q == '0) ? len_i : len_q;
   assign line_last = (cnt_q == len_cur);
   assign word_o    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {data_i, dest_i, meta_i, line_last};
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cnt_q    <= '0;
         len_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
            cnt_q    <= line_last ? '0 : cnt_q + PKT_SIZE_BITS'(1);
            if (cnt_q == '0) begin
               len_q <= len_i;
            end
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
         end
         count_q <= count_q + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/sl3_tx_packet_arbiter.sv
// N-channel SL3 TX packet arbiter: frames each channel, then forwards whole packets
// round-robin through a registered valid/ready stage. Build option: SL3_TX_WEIGHTED_ARB_EN.
//
// state     | meaning
// ST_IDLE   | no lock; pick next non-empty channel from rr_ptr upward
// ST_LOCKED | forwarding the granted channel until its packet's last line is popped
module sl3_tx_packet_arbiter
   import sl3_tx_packet_arbiter_pkg::*;
#(
   parameter int NUM_CH          = 3,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int FIFO_DEPTH_BITS = 9,
   parameter int PKT_SIZE_BITS   = 8,
   parameter int DEV_ID_W        = DEF_DEV_ID_W,
   parameter int META_W          = DEF_META_W
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_core,
   input  logic [NUM_CH*DATA_W-1:0]          ch_data,
   input  logic [NUM_CH-1:0]                 ch_valid,
   output logic [NUM_CH-1:0]                 ch_ready,
   input  logic [NUM_CH*DEV_ID_W-1:0]        ch_dest,
   input  logic [NUM_CH*META_W-1:0]          ch_metadata,
   input  logic [NUM_CH*PKT_SIZE_BITS-1:0]   ch_pkt_numcls_minus_one,
   input  logic [NUM_CH*4-1:0]               ch_weight,
   output logic [DATA_W-1:0]                 tx_data,
   output logic [DEV_ID_W+5:0]               tx_address,
   output logic [META_W-1:0]                 tx_metadata,
   output logic                              tx_last,
   output logic                              tx_valid,
   input  logic                              tx_ready,
   output logic [31:0]                       num_sent_lines,
   output logic [31:0]                       num_sent_packets,
   output logic [$clog2(NUM_CH)-1:0]         grant_ch
);

   localparam int CH_W   = $clog2(NUM_CH);
   localparam int WORD_W = DATA_W + DEV_ID_W + META_W + 1;

   logic                clr;
   logic [NUM_CH-1:0]   fifo_empty, fifo_multi, pop_vec, accept;
   logic [WORD_W-1:0]   ch_word [NUM_CH];
   logic [WORD_W-1:0]   word_sel;
   logic                pop_go, req_any;
   logic [CH_W-1:0]     rr_sel_d;

   arb_state_t          state_q;
   logic [CH_W-1:0]     grant_q, rr_ptr_q;
   logic                tx_valid_q, tx_last_q;
   logic [DATA_W-1:0]   tx_data_q;
   logic [DEV_ID_W-1:0] tx_dest_q;
   logic [META_W-1:0]   tx_meta_q;
   logic [31:0]         lines_q, pkts_q;

   assign clr    = ~rst_n | start_core;
   assign accept = ch_valid & ch_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sl3_tx_packet_arbiter_ch_framer #(
         .DATA_W        (DATA_W),
         .DEV_ID_W      (DEV_ID_W),
         .META_W        (META_W),
         .PKT_SIZE_BITS (PKT_SIZE_BITS),
         .DEPTH_BITS    (FIFO_DEPTH_BITS)
      ) u_framer (
         .clk     (clk),
         .clr_i   (clr),
         .data_i  (ch_data[g*DATA_W +: DATA_W]),
         .dest_i  (ch_dest[g*DEV_ID_W +: DEV_ID_W]),
         .meta_i  (ch_metadata[g*META_W +: META_W]),
         .valid_i (ch_valid[g]),
         .len_i   (ch_pkt_numcls_minus_one[g*PKT_SIZE_BITS +: PKT_SIZE_BITS]),
         .pop_i   (pop_vec[g]),
         .ready_o (ch_ready[g]),
         .word_o  (ch_word[g]),
         .empty_o (fifo_empty[g]),
         .multi_o (fifo_multi[g])
      );
   end

   // Scan from the highest offset down so the last hit is the first channel at/after rr_ptr.
   always_comb begin
      int idx;
      idx      = 0;
      rr_sel_d = rr_ptr_q;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!fifo_empty[idx]) rr_sel_d = CH_W'(idx);
      end
   end

   assign req_any  = ~&fifo_empty;
   assign word_sel = ch_word[grant_q];
   assign pop_go   = (state_q == ST_LOCKED) & ~fifo_empty[grant_q] & (~tx_valid_q | tx_ready);

   always_comb begin
      pop_vec          = '0;
      pop_vec[grant_q] = pop_go;
   end

`ifdef SL3_TX_WEIGHTED_ARB_EN
   logic [3:0] quota_q, weight_sel;
   always_comb begin
      weight_sel = ch_weight[int'(rr_sel_d)*4 +: 4];
      if (weight_sel == 4'd0) weight_sel = 4'd1;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{ch_weight, fifo_multi};
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         tx_data_q  <= '0;
         tx_dest_q  <= '0;
         tx_meta_q  <= '0;
         lines_q    <= '0;
         pkts_q     <= '0;
`ifdef SL3_TX_WEIGHTED_ARB_EN
         quota_q    <= 4'd1;
`endif
      end else begin
         if (pop_go) begin
            {tx_data_q, tx_dest_q, tx_meta_q, tx_last_q} <= word_sel;
            tx_valid_q <= 1'b1;
         end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
         end

         lines_q <= lines_q + 32'($countones(accept));
         if (tx_valid_q && tx_ready && tx_last_q) begin
            pkts_q <= pkts_q + 32'd1;
         end

         case (state_q)
            ST_IDLE: begin
               if (req_any) begin
                  grant_q <= rr_sel_d;
                  state_q <= ST_LOCKED;
`ifdef SL3_TX_WEIGHTED_ARB_EN
                  quota_q <= weight_sel;
`endif
               end
            end
            ST_LOCKED: begin
               if (pop_go && word_sel[0]) begin
`ifdef SL3_TX_WEIGHTED_ARB_EN
                  if (quota_q > 4'd1 && fifo_multi[grant_q]) begin
                     quota_q <= quota_q - 4'd1;
                  end else begin
                     rr_ptr_q <= CH_W'(rr_next(int'(grant_q), NUM_CH));
                     state_q  <= ST_IDLE;
                  end
`else
                  rr_ptr_q <= CH_W'(rr_next(int'(grant_q), NUM_CH));
                  state_q  <= ST_IDLE;
`endif
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_data          = tx_data_q;
   assign tx_address       = {2'b00, tx_dest_q, 4'b0000};
   assign tx_metadata      = tx_meta_q;
   assign tx_last          = tx_last_q;
   assign tx_valid         = tx_valid_q;
   assign num_sent_lines   = lines_q;
   assign num_sent_packets = pkts_q;
   assign grant_ch         = grant_q;

endmodule

// File: tb/tb_sl3_tx_packet_arbiter.sv
// Directed bench for sl3_tx_packet_arbiter (default build, NUM_CH=3, 512-line FIFOs).
module tb_sl3_tx_packet_arbiter;

   localparam int NUM_CH = 3;
   localparam int DATA_W = 128;
   localparam int DEV_W  = 4;
   localparam int META_W = 16;
   localparam int PSB    = 8;

   logic                       clk = 1'b0;
   logic                       rst_n, start_core, tx_ready;
   logic [NUM_CH*DATA_W-1:0]   ch_data;
   logic [NUM_CH-1:0]          ch_valid, ch_ready;
   logic [NUM_CH*DEV_W-1:0]    ch_dest;
   logic [NUM_CH*META_W-1:0]   ch_metadata;
   logic [NUM_CH*PSB-1:0]      ch_len;
   logic [NUM_CH*4-1:0]        ch_weight;
   logic [DATA_W-1:0]          tx_data;
   logic [DEV_W+5:0]           tx_address;
   logic [META_W-1:0]          tx_metadata;
   logic                       tx_last, tx_valid;
   logic [31:0]                num_sent_lines, num_sent_packets;
   logic [1:0]                 grant_ch;

   always #5 clk = ~clk;

   sl3_tx_packet_arbiter dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .start_core              (start_core),
      .ch_data                 (ch_data),
      .ch_valid                (ch_valid),
      .ch_ready                (ch_ready),
      .ch_dest                 (ch_dest),
      .ch_metadata             (ch_metadata),
      .ch_pkt_numcls_minus_one (ch_len),
      .ch_weight               (ch_weight),
      .tx_data                 (tx_data),
      .tx_address              (tx_address),
      .tx_metadata             (tx_metadata),
      .tx_last                 (tx_last),
      .tx_valid                (tx_valid),
      .tx_ready                (tx_ready),
      .num_sent_lines          (num_sent_lines),
      .num_sent_packets        (num_sent_packets),
      .grant_ch                (grant_ch)
   );

   typedef struct packed {
      logic [7:0]  ch;
      logic [15:0] seq;
      logic        last;
      logic [7:0]  grant;
      logic [9:0]  addr;
      logic [15:0] meta;
   } beat_t;

   int         total = 0;
   int         bad   = 0;
   int         rem [NUM_CH];
   int         seq [NUM_CH];
   logic [7:0] len_cfg [NUM_CH];
   int         cyc = 0, acc_total = 0, first_acc = -1, first_vld = -1;
   beat_t      beats [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_valid[i] = (rem[i] > 0);
         ch_data[i*DATA_W +: DATA_W] = {96'b0, 8'(i), 8'h00, 16'(seq[i])};
         ch_dest[i*DEV_W +: DEV_W] = 4'(i + 1);
         ch_metadata[i*META_W +: META_W] = 16'hA0 + 16'(i);
         ch_len[i*PSB +: PSB] = len_cfg[i];
      end
   endtask

   // One clock: note handshakes due at the coming edge, cross it, advance the sources.
   task automatic step();
      logic [NUM_CH-1:0] acc;
      beat_t b;
      acc = ch_valid & ch_ready;
      if (acc != '0 && first_acc < 0) first_acc = cyc + 1;
      if (tx_valid && first_vld < 0) first_vld = cyc;
      if (tx_valid && tx_ready) begin
         b.ch    = tx_data[31:24];
         b.seq   = tx_data[15:0];
         b.last  = tx_last;
         b.grant = 8'(grant_ch);
         b.addr  = tx_address;
         b.meta  = tx_metadata;
         beats.push_back(b);
      end
      @(posedge clk); #1; cyc++;
      for (int i = 0; i < NUM_CH; i++) begin
         if (acc[i]) begin
            seq[i]++;
            rem[i]--;
            acc_total++;
         end
      end
      drive();
   endtask

   task automatic clear_all(input bit use_rst);
      for (int i = 0; i < NUM_CH; i++) begin
         rem[i] = 0;
         seq[i] = 0;
      end
      drive();
      if (use_rst) rst_n = 1'b0;
      else start_core = 1'b1;
      @(posedge clk); #1; cyc++;
      rst_n      = 1'b1;
      start_core = 1'b0;
      beats.delete();
      acc_total  = 0;
   endtask

   initial begin
      int errs;
      int stall_bad;
      bit got_full;
      bit last_seen;
      logic [DATA_W-1:0] hold;
      int pk;

      rst_n      = 1'b0;
      start_core = 1'b0;
      tx_ready   = 1'b1;
      ch_weight  = {4'd1, 4'd1, 4'd3};
      for (int i = 0; i < NUM_CH; i++) len_cfg[i] = 8'd0;
      clear_all(1'b1);
      rst_n = 1'b0;
      clear_all(1'b1);

      // Reset state
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_tx_last", 64'(tx_last), 64'd0);
      check("rst_grant", 64'(grant_ch), 64'd0);
      check("rst_lines", 64'(num_sent_lines), 64'd0);
      check("rst_pkts", 64'(num_sent_packets), 64'd0);
      check("rst_ch_ready", 64'(ch_ready), 64'h7);

      // One packet per channel, lengths 16/1/4
      len_cfg[0] = 8'd15; len_cfg[1] = 8'd0; len_cfg[2] = 8'd3;
      rem[0] = 16; rem[1] = 1; rem[2] = 4;
      drive();
      first_acc = -1; first_vld = -1;
      for (int k = 0; k < 200 && beats.size() < 21; k++) step();
      check("t1_beats", 64'(beats.size()), 64'd21);
      check("t1_latency", 64'(first_vld - first_acc), 64'd2);
      for (int k = 0; k < 21 && k < beats.size(); k++) begin
         int ec, es;
         bit el;
         if (k < 16)       begin ec = 0; es = k;      el = (k == 15); end
         else if (k == 16) begin ec = 1; es = 0;      el = 1'b1;      end
         else              begin ec = 2; es = k - 17; el = (k == 20); end
         check($sformatf("t1_beat%0d", k), 64'({beats[k].ch, beats[k].seq, beats[k].last}),
               64'({8'(ec), 16'(es), el}));
         check($sformatf("t1_hdr%0d", k), 64'({beats[k].addr, beats[k].meta}),
               64'({2'b00, 4'(ec + 1), 4'b0000, 16'hA0 + 16'(ec)}));
      end
      check("t1_pkts", 64'(num_sent_packets), 64'd3);
      check("t1_lines", 64'(num_sent_lines), 64'd21);

      // ch0 and ch2 backlogged with 4-line packets alternate strictly
      clear_all(1'b0);
      for (int i = 0; i < NUM_CH; i++) len_cfg[i] = 8'd3;
      rem[0] = 12; rem[2] = 12;
      drive();
      for (int k = 0; k < 300 && beats.size() < 24; k++) step();
      check("t2_beats", 64'(beats.size()), 64'd24);
      for (int k = 0; k < 24 && k < beats.size(); k++) begin
         int ec;
         pk = k / 4;
         ec = (pk % 2 == 1) ? 2 : 0;
         check($sformatf("t2_beat%0d", k),
               64'({beats[k].ch, beats[k].seq, beats[k].last, beats[k].grant}),
               64'({8'(ec), 16'((pk / 2) * 4 + k % 4), (k % 4 == 3), 8'(ec)}));
      end
      check("t2_pkts", 64'(num_sent_packets), 64'd6);

      // Backpressure: stall mid-packet, fill the FIFO, then drain everything
      clear_all(1'b0);
      len_cfg[0] = 8'd15;
      rem[0] = 608;
      drive();
      for (int k = 0; k < 100 && beats.size() < 5; k++) step();
      check("t3_pre_beats", 64'(beats.size()), 64'd5);
      tx_ready  = 1'b0;
      hold      = tx_data;
      stall_bad = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (tx_data !== hold || tx_valid !== 1'b1) stall_bad++;
      end
      check("t3_stall_stable", 64'(stall_bad), 64'd0);
      check("t3_hold_seq", 64'(hold[15:0]), 64'd5);
      got_full = 1'b0;
      for (int k = 0; k < 700; k++) begin
         if (!ch_ready[0]) begin
            got_full = 1'b1;
            break;
         end
         step();
      end
      check("t3_ch_ready_drop", 64'(got_full), 64'd1);
      check("t3_accepts_at_full", 64'(acc_total), 64'd518);
      check("t3_lines_at_full", 64'(num_sent_lines), 64'(acc_total));
      tx_ready = 1'b1;
      for (int k = 0; k < 1500 && beats.size() < 608; k++) step();
      check("t3_beats", 64'(beats.size()), 64'd608);
      errs = 0;
      for (int k = 0; k < beats.size(); k++) begin
         if ({beats[k].ch, beats[k].seq, beats[k].last} !== {8'd0, 16'(k), (k % 16 == 15)}) errs++;
      end
      check("t3_order_errs", 64'(errs), 64'd0);
      check("t3_lines", 64'(num_sent_lines), 64'd608);
      check("t3_pkts", 64'(num_sent_packets), 64'd38);

      // Length change mid-packet only affects the next packet
      clear_all(1'b0);
      len_cfg[1] = 8'd7;
      rem[1] = 10;
      drive();
      for (int k = 0; k < 200 && beats.size() < 10; k++) begin
         step();
         if (seq[1] >= 3 && len_cfg[1] != 8'd1) begin
            len_cfg[1] = 8'd1;
            drive();
         end
      end
      check("t4_beats", 64'(beats.size()), 64'd10);
      for (int k = 0; k < 10 && k < beats.size(); k++) begin
         check($sformatf("t4_beat%0d", k), 64'({beats[k].ch, beats[k].seq, beats[k].last}),
               64'({8'd1, 16'(k), (k == 7 || k == 9)}));
      end
      check("t4_pkts", 64'(num_sent_packets), 64'd2);

      // Soft clear after 5 of 16 lines discards the partial packet
      clear_all(1'b0);
      len_cfg[0] = 8'd15;
      rem[0] = 16;
      drive();
      for (int k = 0; k < 50 && seq[0] < 5; k++) step();
      check("t5_pre_accepts", 64'(seq[0]), 64'd5);
      last_seen = 1'b0;
      foreach (beats[k]) if (beats[k].last) last_seen = 1'b1;
      clear_all(1'b0);
      check("t5_tx_valid", 64'(tx_valid), 64'd0);
      check("t5_tx_last", 64'(tx_last), 64'd0);
      check("t5_lines", 64'(num_sent_lines), 64'd0);
      check("t5_pkts", 64'(num_sent_packets), 64'd0);
      check("t5_no_last", 64'(last_seen), 64'd0);
      check("t5_ch_ready", 64'(ch_ready), 64'h7);
      rem[0] = 16;
      drive();
      for (int k = 0; k < 100 && beats.size() < 16; k++) step();
      check("t5_beats", 64'(beats.size()), 64'd16);
      for (int k = 0; k < 16 && k < beats.size(); k++) begin
         check($sformatf("t5_beat%0d", k), 64'({beats[k].ch, beats[k].seq, beats[k].last}),
               64'({8'd0, 16'(k), (k == 15)}));
      end
      check("t5_pkts_after", 64'(num_sent_packets), 64'd1);
      check("t5_lines_after", 64'(num_sent_lines), 64'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
